// File: rtl/sisr_checker.sv
// sisr_checker: scan BIST response compactor.
// Sequences shift/capture windows, compacts scan_out into an 8-bit SISR
// (x^8+x^6+x^5+x^4+1) and compares against a golden signature at end of run.
// Optional build macro: SISR_SKIP_FIRST_UNLOAD_EN -- when defined, the first
// shift window (unknown initial chain contents) is not compacted.
module sisr_checker #(
  parameter int CHAIN_LEN    = 8,
  parameter int NUM_PATTERNS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       scan_out,
  input  logic [7:0] golden,
  output logic       scan_enable,
  output logic       gen_reset,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam int SH_W  = $clog2(CHAIN_LEN);
  localparam int PAT_W = $clog2(NUM_PATTERNS + 1);

  localparam logic [SH_W-1:0]  SHIFT_LAST = SH_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_TOTAL  = PAT_W'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SH_W-1:0]  shift_cnt;
  logic [PAT_W-1:0] pat_cnt;
  logic [7:0]       sig;
  logic             window_end;
  logic             launch;
  logic             compact_en;
  logic             fb;

  assign window_end = (shift_cnt == SHIFT_LAST);
  assign launch     = ((state == IDLE) || (state == DONE)) && start;
  assign fb         = sig[7] ^ sig[5] ^ sig[4] ^ sig[3] ^ scan_out;

`ifdef SISR_SKIP_FIRST_UNLOAD_EN
  // pat_cnt is still zero throughout the first window, so it doubles as the mask
  assign compact_en = (state == SHIFT) && (pat_cnt != '0);
`else
  assign compact_en = (state == SHIFT);
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (window_end) begin
          if (pat_cnt < PAT_TOTAL) state_nxt = CAPTURE;
          else                     state_nxt = COMPARE;
        end
      end
      CAPTURE: state_nxt = SHIFT;
      COMPARE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, signature register and pass flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig       <= '0;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      pass      <= 1'b0;
    end else if (launch) begin
      sig       <= '0;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      pass      <= 1'b0;
    end else begin
      if (compact_en) sig <= {sig[6:0], fb};
      if (state == SHIFT) shift_cnt <= window_end ? '0 : shift_cnt + 1'b1;
      if (state == CAPTURE) pat_cnt <= pat_cnt + 1'b1;
      if (state == COMPARE) pass <= (sig == golden);
    end
  end

  // Outputs decoded directly from the state register
  always_comb begin
    scan_enable = (state == SHIFT);
    gen_reset   = (state == IDLE) || (state == DONE);
    busy        = (state == SHIFT) || (state == CAPTURE) || (state == COMPARE);
    done        = (state == DONE);
  end

  assign signature = sig;

endmodule

// File: tb/tb_sisr_checker.sv
// tb_sisr_checker: directed-vector bench for sisr_checker.
// Small instance (CHAIN_LEN=8, NUM_PATTERNS=1) driven with all-ones scan data,
// default instance driven with all-zeros scan data.
module tb_sisr_checker;

  logic       clock = 1'b0;
  logic       reset;

  logic       a_start, a_scan;
  logic [7:0] a_golden;
  logic       a_se, a_gr, a_busy, a_done, a_pass;
  logic [7:0] a_sig;

  logic       b_start, b_scan;
  logic [7:0] b_golden;
  logic       b_se, b_gr, b_busy, b_done, b_pass;
  logic [7:0] b_sig;

  int total = 0;
  int bad   = 0;

`ifdef SISR_SKIP_FIRST_UNLOAD_EN
  localparam logic [7:0] EXP_ONES = 8'hF4;
`else
  localparam logic [7:0] EXP_ONES = 8'h39;
`endif

  always #5 clock = ~clock;

  sisr_checker #(.CHAIN_LEN(8), .NUM_PATTERNS(1)) u_small (
    .clock      (clock),
    .reset      (reset),
    .start      (a_start),
    .scan_out   (a_scan),
    .golden     (a_golden),
    .scan_enable(a_se),
    .gen_reset  (a_gr),
    .busy       (a_busy),
    .done       (a_done),
    .pass       (a_pass),
    .signature  (a_sig)
  );

  sisr_checker u_dflt (
    .clock      (clock),
    .reset      (reset),
    .start      (b_start),
    .scan_out   (b_scan),
    .golden     (b_golden),
    .scan_enable(b_se),
    .gen_reset  (b_gr),
    .busy       (b_busy),
    .done       (b_done),
    .pass       (b_pass),
    .signature  (b_sig)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run on the small instance. scan_out is 1 except before edge flip_edge;
  // start is re-pulsed before edge extra_start_edge (must be ignored).
  task automatic run_a(input string tag, input logic [7:0] gold, input int flip_edge,
                       input int extra_start_edge);
    int done_edge;
    done_edge = -1;
    a_golden  = gold;
    @(posedge clock); #1;
    a_start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      a_scan = (e == flip_edge) ? 1'b0 : 1'b1;
      @(posedge clock); #1;
      a_start = (e + 1 == extra_start_edge);
      if (e == 0) begin
        check({tag, "_e0_busy"}, int'(a_busy), 1);
        check({tag, "_e0_se"},   int'(a_se),   1);
        check({tag, "_e0_gr"},   int'(a_gr),   0);
        check({tag, "_e0_sig"},  int'(a_sig),  0);
        check({tag, "_e0_pass"}, int'(a_pass), 0);
        check({tag, "_e0_done"}, int'(a_done), 0);
      end
      if (a_done) begin
        done_edge = e;
        break;
      end
    end
    a_start = 1'b0;
    check({tag, "_done_edge"}, done_edge, 18);
  endtask

  initial begin
    int low_cnt;
    int b_done_edge;

    reset    = 1'b1;
    a_start  = 1'b0; a_scan = 1'b1; a_golden = 8'h00;
    b_start  = 1'b0; b_scan = 1'b0; b_golden = 8'h00;
    #1;
    check("rst_se",   int'(a_se),   0);
    check("rst_gr",   int'(a_gr),   1);
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_pass", int'(a_pass), 0);
    check("rst_sig",  int'(a_sig),  0);
    #12 reset = 1'b0;

    // All-ones run, matching golden
    run_a("r1", EXP_ONES, -1, -1);
    check("r1_sig",  int'(a_sig),  int'(EXP_ONES));
    check("r1_pass", int'(a_pass), 1);
    repeat (3) @(posedge clock);
    #1;
    check("r1_hold_done", int'(a_done), 1);
    check("r1_hold_pass", int'(a_pass), 1);
    check("r1_hold_sig",  int'(a_sig),  int'(EXP_ONES));
    check("r1_hold_gr",   int'(a_gr),   1);

    // Restart from DONE with a wrong golden: pass clears at edge 0, ends 0
    run_a("r2", EXP_ONES ^ 8'h01, -1, -1);
    check("r2_sig",  int'(a_sig),  int'(EXP_ONES));
    check("r2_pass", int'(a_pass), 0);

    // start pulsed mid-SHIFT is ignored
    run_a("r3", EXP_ONES, -1, 5);
    check("r3_sig",  int'(a_sig),  int'(EXP_ONES));
    check("r3_pass", int'(a_pass), 1);

    // Single flipped bit in the first window
    run_a("f1", EXP_ONES, 3, -1);
`ifdef SISR_SKIP_FIRST_UNLOAD_EN
    check("f1_sig",  int'(a_sig),  int'(EXP_ONES));
    check("f1_pass", int'(a_pass), 1);
`else
    check("f1_sig_differs", int'(a_sig != EXP_ONES), 1);
    check("f1_pass", int'(a_pass), 0);
`endif

    // Single flipped bit in the second window
    run_a("f2", EXP_ONES, 12, -1);
    check("f2_sig_differs", int'(a_sig != EXP_ONES), 1);
    check("f2_pass", int'(a_pass), 0);

    // Asynchronous reset in the middle of SHIFT
    a_golden = EXP_ONES;
    @(posedge clock); #1;
    a_start = 1'b1;
    @(posedge clock); #1;
    a_start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("mr_pre_se", int'(a_se), 1);
    #2 reset = 1'b1;
    #1;
    check("mr_se",   int'(a_se),   0);
    check("mr_gr",   int'(a_gr),   1);
    check("mr_busy", int'(a_busy), 0);
    check("mr_done", int'(a_done), 0);
    check("mr_pass", int'(a_pass), 0);
    check("mr_sig",  int'(a_sig),  0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    check("mr_idle_busy", int'(a_busy), 0);
    check("mr_idle_gr",   int'(a_gr),   1);

    // Default parameters, all-zeros scan data
    low_cnt     = 0;
    b_done_edge = -1;
    b_golden    = 8'h00;
    b_scan      = 1'b0;
    @(posedge clock); #1;
    b_start = 1'b1;
    for (int e = 0; e < 200; e++) begin
      @(posedge clock); #1;
      b_start = 1'b0;
      if (e < 152 && !b_se) low_cnt++;
      if (b_done) begin
        b_done_edge = e;
        break;
      end
    end
    check("d_done_edge", b_done_edge, 153);
    check("d_se_low",    low_cnt,     16);
    check("d_sig",       int'(b_sig), 0);
    check("d_pass",      int'(b_pass), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
